// File: rtl/tpu_sequencer.sv
// tpu_sequencer: issues systolic-array TPU opcodes (matmul, lam, lbm, lacc,
// racc) from execute. Element loads become one-cycle write strobes, matmul
// starts the array and tracks its run time, and racc reads the accumulator
// and returns the value on a one-cycle writeback pulse.
//
// Handshake: an instruction is taken when instr_valid_i is high, the opcode
// is a TPU opcode, stall_o is low and rst_i is low; the upstream pipeline
// must keep presenting the same instruction for every cycle that stall_o is
// high. All strobes appear for exactly one cycle, in the cycle after the
// instruction is taken.
module tpu_sequencer #(
    parameter int DIM        = 4,
    parameter int DATA_W     = 32,
    parameter int RUN_CYCLES = 10,
    parameter int ACC_RD_LAT = 1,
    localparam int IDX_W     = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_valid_i,
    input  logic [6:0]        op_i,
    input  logic [31:0]       rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    output logic              stall_o,
    output logic              a_wr_en_o,
    output logic              b_wr_en_o,
    output logic              c_wr_en_o,
    output logic [IDX_W-1:0]  tpu_row_o,
    output logic [IDX_W-1:0]  tpu_col_o,
    output logic [DATA_W-1:0] tpu_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              acc_rd_en_o,
    input  logic [DATA_W-1:0] acc_rd_data_i,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [1:0]        dbg_state_o
);

    localparam logic [6:0] OP_MATMUL = 7'h50;
    localparam logic [6:0] OP_LAM    = 7'h51;
    localparam logic [6:0] OP_LBM    = 7'h52;
    localparam logic [6:0] OP_LACC   = 7'h53;
    localparam logic [6:0] OP_RACC   = 7'h54;

    // One counter serves both the matmul run time and the read latency.
    localparam int CNT_MAX = (RUN_CYCLES > ACC_RD_LAT) ? RUN_CYCLES : ACC_RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RD_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a_wr;
    logic               r_b_wr;
    logic               r_c_wr;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic [DATA_W-1:0]  r_data;
    logic               r_start;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_en;
    logic               r_wb_valid;
    logic [DATA_W-1:0]  r_wb_data;

    logic               w_is_tpu;
    logic               w_stall;
    logic               w_accept;
    logic [IDX_W-1:0]   w_row;
    logic [IDX_W-1:0]   w_col;
    logic               w_unused_rs1;

    // Only the low IDX_W bits of each index field are used; larger indices wrap.
    assign w_row        = rs1_data_i[8 +: IDX_W];
    assign w_col        = rs1_data_i[0 +: IDX_W];
    assign w_unused_rs1 = ^rs1_data_i;

    assign w_is_tpu = (op_i >= OP_MATMUL) && (op_i <= OP_RACC);

    // Stall: TPU ops wait while the array runs; everything waits during a read.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_RUN:     w_stall = instr_valid_i & w_is_tpu;
            S_RD_WAIT: w_stall = instr_valid_i;
            default:   w_stall = 1'b0;
        endcase
    end

    assign w_accept = instr_valid_i & w_is_tpu & ~w_stall;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_a_wr     <= 1'b0;
            r_b_wr     <= 1'b0;
            r_c_wr     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_data     <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            r_a_wr     <= 1'b0;
            r_b_wr     <= 1'b0;
            r_c_wr     <= 1'b0;
            r_start    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op_i)
                            OP_MATMUL: begin
                                r_start <= 1'b1;
                                r_busy  <= 1'b1;
                                r_done  <= (RUN_CYCLES == 1);
                                r_cnt   <= CNT_W'(RUN_CYCLES - 1);
                                r_state <= S_RUN;
                            end
                            OP_LAM: begin
                                r_a_wr <= 1'b1;
                                r_row  <= w_row;
                                r_col  <= w_col;
                                r_data <= rs2_data_i;
                            end
                            OP_LBM: begin
                                r_b_wr <= 1'b1;
                                r_row  <= w_row;
                                r_col  <= w_col;
                                r_data <= rs2_data_i;
                            end
                            OP_LACC: begin
                                r_c_wr <= 1'b1;
                                r_row  <= w_row;
                                r_col  <= w_col;
                                r_data <= rs2_data_i;
                            end
                            OP_RACC: begin
                                r_rd_en <= 1'b1;
                                r_row   <= w_row;
                                r_col   <= w_col;
                                r_cnt   <= CNT_W'(ACC_RD_LAT);
                                r_state <= S_RD_WAIT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_done <= (r_cnt == CNT_W'(1));
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= acc_rd_data_i;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_o     = w_stall;
    assign a_wr_en_o   = r_a_wr;
    assign b_wr_en_o   = r_b_wr;
    assign c_wr_en_o   = r_c_wr;
    assign tpu_row_o   = r_row;
    assign tpu_col_o   = r_col;
    assign tpu_data_o  = r_data;
    assign start_o     = r_start;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign acc_rd_en_o = r_rd_en;
    assign wb_valid_o  = r_wb_valid;
    assign wb_data_o   = r_wb_data;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Testbench for tpu_sequencer: directed steps followed by random traffic,
// every cycle compared against a timeline model of busy / read windows.
module tb_tpu_sequencer;

    localparam int DIM = 4;
    localparam int DATA_W = 32;
    localparam int RC = 10;
    localparam int LAT = 1;
    localparam int IDX_W = 2;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic [6:0]        op;
    logic [31:0]       rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] acc_rd_data;
    logic              stall_o, a_wr_en_o, b_wr_en_o, c_wr_en_o;
    logic [IDX_W-1:0]  tpu_row_o, tpu_col_o;
    logic [DATA_W-1:0] tpu_data_o, wb_data_o;
    logic              start_o, busy_o, done_o, acc_rd_en_o, wb_valid_o;
    logic [1:0]        dbg_state_o;

    tpu_sequencer #(.DIM(DIM), .DATA_W(DATA_W), .RUN_CYCLES(RC), .ACC_RD_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .op_i(op),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .stall_o(stall_o),
        .a_wr_en_o(a_wr_en_o), .b_wr_en_o(b_wr_en_o), .c_wr_en_o(c_wr_en_o),
        .tpu_row_o(tpu_row_o), .tpu_col_o(tpu_col_o), .tpu_data_o(tpu_data_o),
        .start_o(start_o), .busy_o(busy_o), .done_o(done_o),
        .acc_rd_en_o(acc_rd_en_o), .acc_rd_data_i(acc_rd_data),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .dbg_state_o(dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Timeline model: cycle numbers of the matmul busy window and racc wait window.
    int cyc = 0;
    int run_lo = -100, run_hi = -100;
    int rd_lo = -100, rd_hi = -100;
    int e_row = 0, e_col = 0;
    logic [31:0] e_data = 0, e_wb = 0;
    logic e_start, e_a, e_b, e_c, e_rd, e_wbv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [31:0] a, input logic [31:0] d);
        instr_valid = v;
        op = o;
        rs1 = a;
        rs2 = d;
    endtask

    // One clock cycle: check stall, advance the model, check registered outputs.
    task automatic cycle();
        logic is_tpu, in_run, in_rd, e_stall, acc;
        #1;
        is_tpu = (op >= 7'h50) && (op <= 7'h54);
        in_run = (cyc >= run_lo) && (cyc <= run_hi);
        in_rd = (cyc >= rd_lo) && (cyc <= rd_hi);
        e_stall = in_rd ? instr_valid : (in_run ? (instr_valid & is_tpu) : 1'b0);
        check("stall", 32'(stall_o), 32'(e_stall));
        acc = instr_valid & is_tpu & ~e_stall & ~rst;
        e_start = 0; e_a = 0; e_b = 0; e_c = 0; e_rd = 0; e_wbv = 0;
        if (rst) begin
            run_lo = -100; run_hi = -100; rd_lo = -100; rd_hi = -100;
            e_row = 0; e_col = 0; e_data = 0; e_wb = 0;
        end else begin
            if (cyc == rd_hi) begin
                e_wbv = 1;
                e_wb = acc_rd_data;
            end
            if (acc) begin
                if (op != 7'h50) begin
                    e_row = ((rs1 >> 8) & 32'hFF) % DIM;
                    e_col = (rs1 & 32'hFF) % DIM;
                end
                case (op)
                    7'h50: begin e_start = 1; run_lo = cyc + 1; run_hi = cyc + RC; end
                    7'h51: begin e_a = 1; e_data = rs2; end
                    7'h52: begin e_b = 1; e_data = rs2; end
                    7'h53: begin e_c = 1; e_data = rs2; end
                    default: begin e_rd = 1; rd_lo = cyc + 1; rd_hi = cyc + 1 + LAT; end
                endcase
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("start", 32'(start_o), 32'(e_start));
        check("busy", 32'(busy_o), 32'((cyc >= run_lo) && (cyc <= run_hi)));
        check("done", 32'(done_o), 32'(cyc == run_hi));
        check("a_wr", 32'(a_wr_en_o), 32'(e_a));
        check("b_wr", 32'(b_wr_en_o), 32'(e_b));
        check("c_wr", 32'(c_wr_en_o), 32'(e_c));
        check("rd_en", 32'(acc_rd_en_o), 32'(e_rd));
        check("wb_valid", 32'(wb_valid_o), 32'(e_wbv));
        check("row", 32'(tpu_row_o), 32'(e_row));
        check("col", 32'(tpu_col_o), 32'(e_col));
        check("data", tpu_data_o, e_data);
        check("wb_data", wb_data_o, e_wb);
        check("idle", 32'(dbg_state_o == 2'd0),
              32'(!((cyc >= run_lo && cyc <= run_hi) || (cyc >= rd_lo && cyc <= rd_hi))));
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 7'h00, 32'h0, 32'h0);
            cycle();
        end
    endtask

    initial begin
        int k;
        logic [6:0] ops[9];
        ops = '{7'h50, 7'h51, 7'h52, 7'h53, 7'h54, 7'h01, 7'h55, 7'h5F, 7'h33};

        // Reset block
        rst = 1'b1;
        acc_rd_data = '0;
        drive(1'b0, 7'h00, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_data", tpu_data_o, 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // lam basic and index wrap
        drive(1'b1, 7'h51, 32'h0102, 32'hDEADBEEF);
        cycle();
        check("lam_a_wr", 32'(a_wr_en_o), 32'd1);
        check("lam_row", 32'(tpu_row_o), 32'd1);
        check("lam_col", 32'(tpu_col_o), 32'd2);
        check("lam_data", tpu_data_o, 32'hDEADBEEF);
        drive(1'b1, 7'h51, 32'h0506, 32'h0BADF00D);
        cycle();
        check("wrap_row", 32'(tpu_row_o), 32'd1);
        check("wrap_col", 32'(tpu_col_o), 32'd2);
        idle_cycles(1);

        // matmul then lbm held until accepted
        drive(1'b1, 7'h50, 32'h0, 32'h0);
        cycle();
        check("mm_start", 32'(start_o), 32'd1);
        for (int i = 0; i < RC + 1; i++) begin
            drive(1'b1, 7'h52, 32'h0201, 32'h5555AAAA);
            cycle();
        end
        check("lbm_after_run", 32'(b_wr_en_o), 32'd1);
        idle_cycles(1);

        // matmul with a non-TPU add during the run
        drive(1'b1, 7'h50, 32'h0, 32'h0);
        cycle();
        idle_cycles(2);
        drive(1'b1, 7'h01, 32'h0, 32'h0);
        cycle();
        check("add_busy", 32'(busy_o), 32'd1);
        idle_cycles(RC);

        // racc with an add stalled behind it
        drive(1'b1, 7'h54, 32'h0303, 32'h0);
        cycle();
        check("racc_rd_en", 32'(acc_rd_en_o), 32'd1);
        drive(1'b1, 7'h01, 32'h0, 32'h0);
        acc_rd_data = 32'hFFFF0000;
        cycle();
        acc_rd_data = 32'h1234;
        cycle();
        check("racc_wb_valid", 32'(wb_valid_o), 32'd1);
        check("racc_wb_data", wb_data_o, 32'h1234);
        idle_cycles(1);

        // matmul interrupted by reset, then a fresh matmul
        drive(1'b1, 7'h50, 32'h0, 32'h0);
        cycle();
        idle_cycles(3);
        rst = 1'b1;
        drive(1'b1, 7'h50, 32'h0, 32'h0);
        cycle();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_state", 32'(dbg_state_o), 32'd0);
        idle_cycles(1);
        drive(1'b1, 7'h50, 32'h0, 32'h0);
        cycle();
        check("post_rst_start", 32'(start_o), 32'd1);
        idle_cycles(RC);

        // back-to-back element loads
        drive(1'b1, 7'h51, 32'h0000, 32'h11);
        cycle();
        drive(1'b1, 7'h52, 32'h0101, 32'h22);
        cycle();
        drive(1'b1, 7'h53, 32'h0203, 32'h33);
        cycle();
        check("lacc_c_wr", 32'(c_wr_en_o), 32'd1);
        idle_cycles(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 8);
            drive(($urandom_range(0, 9) < 7), ops[k], $urandom, $urandom);
            if (k == 8) op = 7'($urandom);
            acc_rd_data = $urandom;
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_cycles(RC + 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Issues TPU-class opcodes (0x50 to 0x54: matmul, lam, lbm, lacc, racc) from execute to the systolic-array TPU.
- Converts register operands into A, B and C element write strobes and the matmul start pulse, then counts the array run time.
- Performs accumulator reads and returns the result on a writeback port.
- Stalls the pipeline on structural hazards; non-TPU instructions pass through untouched.

Parameters:
DIM, 4, systolic array dimension (DIM x DIM elements).
DATA_W, 32, element, operand and writeback width.
RUN_CYCLES, 10, cycles busy after a matmul start (3*DIM-2). Must be >= 1.
ACC_RD_LAT, 1, cycles from acc_rd_en_o to valid acc_rd_data_i. Must be >= 1.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
instr_valid_i  in  1  instruction present in execute this cycle
op_i  in  7  opcode of that instruction
rs1_data_i  in  32  element index: row=[15:8], col=[7:0], each truncated to IDX_W=$clog2(DIM) bits
rs2_data_i  in  DATA_W  element write data
stall_o  out  1  freeze pipeline (combinational)
a_wr_en_o  out  1  write A element (lam)
b_wr_en_o  out  1  write B element (lbm)
c_wr_en_o  out  1  write accumulator element (lacc)
tpu_row_o  out  IDX_W  element row
tpu_col_o  out  IDX_W  element column
tpu_data_o  out  DATA_W  element write data
start_o  out  1  matmul start pulse
busy_o  out  1  array running
done_o  out  1  final busy cycle
acc_rd_en_o  out  1  accumulator read strobe (racc)
acc_rd_data_i  in  DATA_W  accumulator read data
wb_valid_o  out  1  racc result valid, one-cycle pulse
wb_data_o  out  DATA_W  racc result

Behaviour:
- is_tpu = op_i in 0x50..0x54. Opcodes 0x55..0x5F and all non-TPU opcodes are ignored and never cause a stall.
- States: IDLE, RUN, RD_WAIT.
- stall_o:
  - RUN: instr_valid_i & is_tpu.
  - RD_WAIT: instr_valid_i, for any opcode.
  - IDLE: 0.
- Accept: instr_valid_i & is_tpu & ~stall_o in cycle 0.
- All outputs are registered except stall_o. Every strobe appears in cycle 1 for exactly one cycle.
- lam, lbm, lacc:
  - Cycle 1 drives the matching wr_en, tpu_row_o, tpu_col_o and tpu_data_o.
  - State stays IDLE, so back-to-back loads are accepted every cycle.
- matmul:
  - Cycle 1: start_o=1, state=RUN.
  - busy_o=1 in cycles 1..RUN_CYCLES. An internal down-counter is loaded with RUN_CYCLES-1.
  - done_o=1 in cycle RUN_CYCLES (coincides with start_o when RUN_CYCLES=1).
  - State returns to IDLE in cycle RUN_CYCLES+1.
  - A TPU op presented in cycle RUN_CYCLES is stalled. One presented in cycle RUN_CYCLES+1 is accepted.
- racc:
  - Cycle 1: acc_rd_en_o=1, row and col driven, state=RD_WAIT.
  - acc_rd_data_i is sampled at the end of cycle 1+ACC_RD_LAT.
  - Cycle 2+ACC_RD_LAT: wb_valid_o=1, wb_data_o holds the sampled value, state=IDLE.
  - wb_data_o holds its value until the next racc.
- Index truncation: only the low IDX_W bits of each rs1 field are used. Out-of-range indices wrap silently.
- Reset, including mid-RUN or mid-RD_WAIT, in the cycle after rst_i:
  - state=IDLE, counter=0.
  - All strobes, busy_o, done_o, wb_valid_o = 0.
  - tpu_row_o, tpu_col_o, tpu_data_o, wb_data_o = 0.
  - A pending racc is dropped with no wb_valid_o.
  - Instructions presented during reset are not accepted.

Test Plan:
- lam with rs1=0x0102 and rs2=0xDEADBEEF in cycle 0 -> cycle 1 a_wr_en_o=1, row=1, col=2, data=0xDEADBEEF; no stall.
- Same lam with DIM=4 and rs1=0x0506 -> row=1, col=2 (wrap).
- matmul in cycle 0, then lbm held valid from cycle 1 -> start_o in cycle 1; busy_o in cycles 1..10; done_o in cycle 10; stall_o in cycles 1..10; lbm accepted in cycle 11; b_wr_en_o in cycle 12.
- matmul, then add (0x01) in cycle 3 -> stall_o=0 and busy_o stays 1.
- racc with rs1=0x0303, ACC_RD_LAT=1, acc_rd_data_i=0x1234 in cycle 2 -> acc_rd_en_o in cycle 1; stall_o for a valid add in cycles 1..2; wb_valid_o=1 and wb_data_o=0x1234 in cycle 3.
- matmul, then rst_i in cycle 4 -> cycle 5 all outputs 0 and state IDLE; a matmul in cycle 6 is accepted with start_o in cycle 7.
- lam, lbm, lacc on consecutive cycles 0, 1, 2 -> strobes in cycles 1, 2, 3; no stall.
